// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, controller states, divider depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_scheduler_div_core.sv
// Unsigned restoring divider, one quotient bit per clock.
// Latency: WIDTH edges after the start edge; done_o stays high until the next start/clear.
// Backpressure: none; start_i is only honoured when the owner is idle, clear_i aborts.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // One restoring step: shift in the next dividend bit, subtract when the divisor fits.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    fits  = (trial >= {1'b0, dvs_q});
    if (clear_i) begin
      quo_d = '0;
      rem_d = '0;
      dvs_d = '0;
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q && (cnt_q != '0)) begin
      rem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], fits};
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o      = run_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_scheduler.sv
// HI/LO owner: sequences fixed-latency MULT/MULTU and iterative DIV/DIVU, handles MTHI/MTLO.
// Latency: MTHI/MTLO 1 edge; MULT MUL_LAT edges; DIV DIV_ITERS+1 edges; o_done pulses the cycle after the write.
// Backpressure: o_busy stalls the pipe front; ops offered while busy are ignored, i_flush aborts.
module muldiv_scheduler
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_op_valid,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             busy_q, done_q, done_d, dbz_q, dbz_d;

  logic             core_start, core_clear, core_done;
  logic [WIDTH-1:0] core_quo, core_rem;
  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [2*WIDTH-1:0] ax, bx, prod;

  // Magnitudes fed to the divider on the accept edge (signed DIV only).
  always_comb begin
    in_a_neg = (i_op == OP_DIV) && i_rs[WIDTH-1];
    in_b_neg = (i_op == OP_DIV) && i_rt[WIDTH-1];
    mag_a    = in_a_neg ? -i_rs : i_rs;
    mag_b    = in_b_neg ? -i_rt : i_rt;
  end

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (core_start),
    .clear_i     (core_clear),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .done_o      (core_done),
    .quotient_o  (core_quo),
    .remainder_o (core_rem)
  );

  // Result shaping: sign-extended product and signed divide fixup from latched operands.
  always_comb begin
    ax    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    bx    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ax * bx;
    a_neg = sgn_q && a_q[WIDTH-1];
    b_neg = sgn_q && b_q[WIDTH-1];
    q_fix = (a_neg ^ b_neg) ? -core_quo : core_quo;
    r_fix = a_neg ? -core_rem : core_rem;
  end

  // Controller next state: accept in IDLE, count MUL edges, wait for the divider, flush aborts.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    b_d        = b_q;
    sgn_d      = sgn_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    core_start = 1'b0;
    core_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_op_valid && !i_flush) begin
          case (i_op)
            OP_MTHI: hi_d = i_rs;
            OP_MTLO: lo_d = i_rs;
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(1);
              a_d     = i_rs;
              b_d     = i_rt;
              sgn_d   = (i_op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d    = ST_DIV;
              core_start = 1'b1;
              a_d        = i_rs;
              b_d        = i_rt;
              sgn_d      = (i_op == OP_DIV);
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (i_flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MUL_LAT)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (i_flush) begin
          state_d    = ST_IDLE;
          core_clear = 1'b1;
        end else if (core_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (b_q == '0) begin
            dbz_d = 1'b1;
            lo_d  = '1;
            hi_d  = a_q;
          end else begin
            lo_d = q_fix;
            hi_d = r_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; busy/done/dbz are registered so the pipe sees glitch-free flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_div_by_zero = dbz_q;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed plus random checks of the HI/LO scheduler against an arithmetic reference model.
// Latency: expects MUL_LAT busy cycles for MULT, 33 for DIV, done pulse in the following cycle.
// Backpressure: never offers an op while o_busy is high; a monitor flags any such offer.
module tb_muldiv_scheduler;
  import muldiv_pkg::*;

  localparam int ML      = 4;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_op_valid = 1'b0;
  logic [2:0]  i_op = '0;
  logic [31:0] i_rs = '0;
  logic [31:0] i_rt = '0;
  logic        i_flush = 1'b0;
  logic        o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_scheduler #(.WIDTH(32), .MUL_LAT(ML)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_op_valid    (i_op_valid),
    .i_op          (i_op),
    .i_rs          (i_rs),
    .i_rt          (i_rt),
    .i_flush       (i_flush),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo)
  );

  always #5 clk = ~clk;

  // The pipeline must never present an op while the unit is busy.
  always @(negedge clk) begin
    if (resetn && i_op_valid) begin
      assert (o_busy !== 1'b1) else begin
        errors++;
        $error("FAIL protocol: op offered while busy");
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what HI/LO become, whether divide-by-zero is flagged, and how long busy lasts.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edbz, output int lat);
    longint      sp, sq, sr;
    logic [63:0] up;
    eh = hi_m; el = lo_m; edbz = 1'b0; lat = 0;
    case (op)
      3'd0: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        up = sp;
        eh = up[63:32]; el = up[31:0]; lat = ML;
      end
      3'd1: begin
        up = {32'd0, rs} * {32'd0, rt};
        eh = up[63:32]; el = up[31:0]; lat = ML;
      end
      3'd2, 3'd3: begin
        lat = DIV_LAT;
        if (rt == 32'd0) begin
          edbz = 1'b1; el = 32'hFFFF_FFFF; eh = rs;
        end else if (op == 3'd2) begin
          sq = longint'($signed(rs)) / longint'($signed(rt));
          sr = longint'($signed(rs)) % longint'($signed(rt));
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          el = rs / rt; eh = rs % rt;
        end
      end
      3'd4: eh = rs;
      3'd5: el = rs;
      default: ;
    endcase
  endtask

  // Issue one op, follow it to completion and compare against the model.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input string tag);
    logic [31:0] eh, el;
    logic        edbz;
    int          lat, n, early;
    model(op, rs, rt, eh, el, edbz, lat);
    i_op_valid = 1'b1; i_op = op; i_rs = rs; i_rt = rt;
    step();
    i_op_valid = 1'b0; i_op = 3'($urandom); i_rs = $urandom; i_rt = $urandom;
    if (lat == 0) begin
      check({tag, "/busy"}, 64'(o_busy), 64'd0);
      check({tag, "/done"}, 64'(o_done), 64'd0);
      check({tag, "/hi"}, 64'(o_hi), 64'(eh));
      check({tag, "/lo"}, 64'(o_lo), 64'(el));
    end else begin
      n = 0; early = 0;
      while (o_busy === 1'b1 && n < 100) begin
        if (o_done !== 1'b0) early++;
        n++;
        step();
      end
      check({tag, "/busy_cycles"}, 64'(n), 64'(lat));
      check({tag, "/early_done"}, 64'(early), 64'd0);
      check({tag, "/done"}, 64'(o_done), 64'd1);
      check({tag, "/dbz"}, 64'(o_div_by_zero), 64'(edbz));
      check({tag, "/hi"}, 64'(o_hi), 64'(eh));
      check({tag, "/lo"}, 64'(o_lo), 64'(el));
    end
    hi_m = eh; lo_m = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    // Reset state.
    resetn = 1'b0;
    step(); step();
    check("rst/busy", 64'(o_busy), 64'd0);
    check("rst/done", 64'(o_done), 64'd0);
    check("rst/dbz", 64'(o_div_by_zero), 64'd0);
    check("rst/hi", 64'(o_hi), 64'd0);
    check("rst/lo", 64'(o_lo), 64'd0);
    resetn = 1'b1;
    step();

    // Directed divides and multiplies, issued back-to-back in the done cycle.
    run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu_m1_2");

    // MTHI then MTLO on consecutive cycles.
    run_op(3'd4, 32'h1234, 32'd0, "mthi");
    run_op(3'd5, 32'h5678, 32'd0, "mtlo");
    check("mtx/hi_kept", 64'(o_hi), 64'h1234);

    // Reserved op codes leave everything alone.
    run_op(3'd6, 32'hDEAD_BEEF, 32'd3, "rsvd6");
    run_op(3'd7, 32'hDEAD_BEEF, 32'd3, "rsvd7");

    // Flush in IDLE blocks even MTHI.
    i_op_valid = 1'b1; i_op = 3'd4; i_rs = 32'hDEAD; i_flush = 1'b1;
    step();
    i_op_valid = 1'b0; i_flush = 1'b0;
    check("idle_flush/hi", 64'(o_hi), 64'(hi_m));
    check("idle_flush/busy", 64'(o_busy), 64'd0);

    // Flush a DIVU mid-flight, then rerun it.
    i_op_valid = 1'b1; i_op = 3'd3; i_rs = 32'd9; i_rt = 32'd3;
    step();
    i_op_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("div_flush/busy", 64'(o_busy), 64'd0);
    check("div_flush/hi", 64'(o_hi), 64'(hi_m));
    check("div_flush/lo", 64'(o_lo), 64'(lo_m));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done !== 1'b0) n++;
      step();
    end
    check("div_flush/no_done", 64'(n), 64'd0);
    run_op(3'd3, 32'd9, 32'd3, "divu_9_3");

    // Flush landing on the MULT write edge wins.
    i_op_valid = 1'b1; i_op = 3'd0; i_rs = 32'd7; i_rt = 32'd6;
    step();
    i_op_valid = 1'b0;
    for (int i = 0; i < ML - 1; i++) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("mul_flush/busy", 64'(o_busy), 64'd0);
    check("mul_flush/done", 64'(o_done), 64'd0);
    check("mul_flush/hi", 64'(o_hi), 64'(hi_m));
    check("mul_flush/lo", 64'(o_lo), 64'(lo_m));
    step();

    // Divide by zero.
    run_op(3'd3, 32'd5, 32'd0, "divu_5_0");
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, "div_neg_0");

    // Reset in the middle of a divide.
    i_op_valid = 1'b1; i_op = 3'd3; i_rs = 32'd1000; i_rt = 32'd3;
    step();
    i_op_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    resetn = 1'b0;
    step();
    check("mid_rst/busy", 64'(o_busy), 64'd0);
    check("mid_rst/hi", 64'(o_hi), 64'd0);
    check("mid_rst/lo", 64'(o_lo), 64'd0);
    check("mid_rst/done", 64'(o_done), 64'd0);
    resetn = 1'b1;
    hi_m = '0; lo_m = '0;
    step();

    // Random op mix against the model.
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rnd%0d", k));
    end

    step();
    check("end/done_low", 64'(o_done), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_scheduler.md
Name: muldiv_scheduler

Overview:
- Multi-cycle MULT/DIV controller for the 5-stage pipeline. Owns the HI/LO registers and sequences an iterative divider and a fixed-latency multiplier.
- Drives o_busy into the pipeline controller's divider-busy input, so the front of the pipe stalls until HI/LO are final.
- Aborts cleanly when the MEM stage raises an exception.

Parameters:
- WIDTH, 32, operand width.
- MUL_LAT, 4, edges from accept to HI/LO write for MULT/MULTU (≥1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- i_op_valid  in  1  EXE-stage HI/LO operation present
- i_op  in  3  operation code (package enum)
- i_rs  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source)
- i_rt  in  WIDTH  operand B (divisor / multiplier)
- i_flush  in  1  MEM exception answer; aborts in-flight operation
- o_busy  out  1  operation in flight (to pipeline controller busy input)
- o_done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- o_div_by_zero  out  1  pulse with o_done when divisor was 0
- o_hi  out  WIDTH  HI register
- o_lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, HI=LO=0, o_busy=0, o_done=0, o_div_by_zero=0, counter=0. Reset mid-operation discards it silently.
- States:
  - IDLE: accept only here.
  - MUL: count MUL_LAT edges.
  - DIV: 32 core iterations plus 1 fixup edge.
- o_busy = (state != IDLE), registered.
- o_done and o_div_by_zero are registered pulses.
- Accept: edge where state==IDLE, i_op_valid=1, i_flush=0. Call this edge E0.
  - MTHI/MTLO: HI or LO <= i_rs at E0; no busy, no o_done.
  - MULT/MULTU: go to MUL, latch operands.
  - DIV/DIVU: go to DIV, latch operands, start core.
  - Reserved op codes are ignored.
- MUL timing: HI:LO <= 64-bit product at edge E(MUL_LAT), state to IDLE.
  - o_busy high for MUL_LAT cycles.
  - o_done high in the cycle after the write edge.
  - MULT is signed, MULTU unsigned.
- DIV timing:
  - Core runs unsigned restoring division on magnitudes at E1..E32.
  - Sign fixup and write at E33: LO=quotient, HI=remainder.
  - Signed fixup: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - -2^31 / -1 → LO=0x80000000, HI=0 (wrap, no trap).
  - o_busy high for 33 cycles.
- Divide by zero: full latency still spent. LO=0xFFFFFFFF, HI=dividend (i_rs), o_div_by_zero=1 alongside o_done.
- i_flush:
  - In MUL/DIV: next edge returns to IDLE, HI/LO unchanged, no o_done, divider core cleared.
  - In IDLE together with i_op_valid: nothing accepted, including MTHI/MTLO.
  - Flush on the write edge: flush wins, no write.
- i_op_valid while busy: ignored. The pipeline guarantees a stall; the bench asserts this never happens.
- Back-to-back: a new op is accepted in the same cycle o_done is high, since state is already IDLE.
- o_hi/o_lo are register outputs. An MFHI/MFLO issued after o_busy falls reads the final value.

Decomposition:
- Package muldiv_pkg holds:
  - op enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, 6–7 reserved.
  - state enum IDLE/MUL/DIV.
  - DIV_ITERS=32.
- Sub-module div_core: unsigned restoring divider.
  - Ports: start, clear, dividend, divisor, 1 bit/cycle iteration, done, quotient, remainder.
  - The scheduler owns sign handling, counters, HI/LO and flush.

Test Plan:
- DIVU rs=100, rt=7 → o_busy high 33 cycles, then LO=14, HI=2, o_done one pulse, o_div_by_zero=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE after 4 edges. MULTU same operands → HI=1, LO=0xFFFFFFFE.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → HI=0x1234, LO=0x5678, o_busy never asserts.
- DIVU 9/3 with i_flush at cycle 10 → IDLE next edge, HI/LO keep prior values, no o_done. A following DIVU 9/3 → LO=3, HI=0.
- DIVU 5/0 → after 33 cycles LO=0xFFFFFFFF, HI=5, o_div_by_zero and o_done pulse together. Reset asserted mid-DIV → HI=LO=0, o_busy=0 next cycle.
